// File: rtl/serial_bit_feeder_if.sv
// Parallel word handshake into the serial bit feeder.
// The source (master) drives the word and its valid flag; the feeder (slave) returns ready.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stage feeding a Moore sequence detector's serial input.
// Words arrive over a valid/ready handshake and leave one bit per clock. The next
// word can be loaded on the final-bit cycle, so consecutive words stream without a gap.
// All outputs are decoded from registers, so they take their reset values as soon as rst falls.
module serial_bit_feeder #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_bit_feeder_if.slave   in_if,
    output logic                 sout,
    output logic                 sout_vld,
    output logic                 last_bit
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // The bit on the wire is the end of the shift register facing the output.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign head_bit      = shreg_q[WIDTH-1];
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_bit      = shreg_q[0];
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // Output and handshake decode; ready also on the final bit so reloads are gapless.
    always_comb begin
        sout_vld       = (state_q == SHIFT);
        last_bit       = sout_vld && (bit_cnt_q == LAST_CNT);
        in_if.in_ready = (state_q == IDLE) || last_bit;
        accept         = in_if.in_valid && in_if.in_ready;
        sout           = sout_vld ? head_bit : IDLE_BIT;
    end

    // Next-state logic: load on accept, shift through the word, reload or idle at its end.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = in_if.in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST_CNT) begin
                    shreg_d   = shreg_shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (accept) begin
                    shreg_d   = in_if.in_data;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // State registers; an active-low reset discards any partially sent word at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first/IDLE_BIT=0 instance (dut_a)
// and an LSB-first/IDLE_BIT=1 instance (dut_b) share the clock and reset.
// Inputs change 1 time unit after posedge (or at negedge); outputs are sampled at negedge.
module tb_serial_bit_feeder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_bit_feeder_if #(.WIDTH(8)) bus_a ();
    serial_bit_feeder_if #(.WIDTH(8)) bus_b ();

    logic sout_a, sout_vld_a, last_bit_a;
    logic sout_b, sout_vld_b, last_bit_b;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_if    (bus_a.slave),
        .sout     (sout_a),
        .sout_vld (sout_vld_a),
        .last_bit (last_bit_a)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_if    (bus_b.slave),
        .sout     (sout_b),
        .sout_vld (sout_vld_b),
        .last_bit (last_bit_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset asserted mid-cycle while dut_a is shifting; outputs must change with no clock edge.
    task automatic test_reset();
        @(posedge clk); #1;
        bus_a.in_data  = 8'hF0;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_a() !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a());
        end
        checks++;
        if (sout_a !== 1'b0) begin
            failures++; $display("FAIL reset_sout got=%b want=0", sout_a);
        end
        checks++;
        if (sout_vld_a !== 1'b0) begin
            failures++; $display("FAIL reset_sout_vld got=%b want=0", sout_vld_a);
        end
        checks++;
        if (last_bit_a !== 1'b0) begin
            failures++; $display("FAIL reset_last_bit got=%b want=0", last_bit_a);
        end
        checks++;
        if (sout_b !== 1'b1) begin
            failures++; $display("FAIL reset_sout_idle1 got=%b want=1", sout_b);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("test_reset: async reset mid-word done");
    endtask

    function automatic logic in_ready_a();
        return bus_a.in_ready;
    endfunction

    // One word 8'b1101_1000, MSB first, last_bit only on bit 8.
    task automatic test_single_word();
        logic [7:0] exp_word;
        exp_word = 8'b1101_1000;
        @(posedge clk); #1;
        bus_a.in_data  = 8'hD8;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sout_a !== exp_word[7-i] || sout_vld_a !== 1'b1) begin
                failures++;
                $display("FAIL single_bit%0d got sout=%b vld=%b want sout=%b vld=1",
                         i, sout_a, sout_vld_a, exp_word[7-i]);
            end
            checks++;
            if (last_bit_a !== (i == 7)) begin
                failures++;
                $display("FAIL single_last%0d got=%b want=%b", i, last_bit_a, (i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (sout_vld_a !== 1'b0 || sout_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_idle got vld=%b sout=%b rdy=%b want vld=0 sout=0 rdy=1",
                     sout_vld_a, sout_a, bus_a.in_ready);
        end
        $display("test_single_word: word 0xD8 sent");
    endtask

    // Two words streamed with valid held: A5 then 3C, no gap cycle.
    task automatic test_back_to_back();
        logic [15:0] exp_stream;
        exp_stream = 16'b1010_0101_0011_1100;
        @(posedge clk); #1;
        bus_a.in_data  = 8'hA5;
        bus_a.in_valid = 1'b1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_idle_ready got=%b want=1", bus_a.in_ready);
        end
        @(posedge clk); #1;
        bus_a.in_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (sout_a !== exp_stream[15-i] || sout_vld_a !== 1'b1) begin
                failures++;
                $display("FAIL b2b_bit%0d got sout=%b vld=%b want sout=%b vld=1",
                         i, sout_a, sout_vld_a, exp_stream[15-i]);
            end
            checks++;
            if (bus_a.in_ready !== (i == 7 || i == 15) || last_bit_a !== (i == 7 || i == 15)) begin
                failures++;
                $display("FAIL b2b_ready%0d got rdy=%b last=%b want %b",
                         i, bus_a.in_ready, last_bit_a, (i == 7 || i == 15));
            end
            if (i == 15) bus_a.in_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (sout_vld_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle got vld=%b rdy=%b want vld=0 rdy=1", sout_vld_a, bus_a.in_ready);
        end
        $display("test_back_to_back: words 0xA5 0x3C sent");
    endtask

    // FF offered on cycle 3 of word 0x96 waits until the last_bit cycle.
    task automatic test_backpressure();
        logic [15:0] exp_stream;
        exp_stream = 16'b1001_0110_1111_1111;
        @(posedge clk); #1;
        bus_a.in_data  = 8'h96;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus_a.in_data  = 8'hFF;
                bus_a.in_valid = 1'b1;
            end
            if (i == 8) bus_a.in_valid = 1'b0;
            checks++;
            if (sout_a !== exp_stream[15-i] || sout_vld_a !== 1'b1) begin
                failures++;
                $display("FAIL bp_bit%0d got sout=%b vld=%b want sout=%b vld=1",
                         i, sout_a, sout_vld_a, exp_stream[15-i]);
            end
            if (i < 8) begin
                checks++;
                if (bus_a.in_ready !== (i == 7)) begin
                    failures++;
                    $display("FAIL bp_ready%0d got=%b want=%b", i, bus_a.in_ready, (i == 7));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (sout_vld_a !== 1'b0) begin
            failures++; $display("FAIL bp_idle got vld=%b want 0", sout_vld_a);
        end
        $display("test_backpressure: words 0x96 0xFF sent");
    endtask

    // Reset after 4 bits of 0xDB; next word 0x5A must go out whole.
    task automatic test_reset_mid_word();
        logic [7:0] first_word;
        logic [7:0] next_word;
        first_word = 8'hDB;
        next_word  = 8'h5A;
        @(posedge clk); #1;
        bus_a.in_data  = 8'hDB;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (sout_a !== first_word[7-i]) begin
                failures++;
                $display("FAIL rmw_bit%0d got=%b want=%b", i, sout_a, first_word[7-i]);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (sout_a !== 1'b0 || sout_vld_a !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmw_reset got sout=%b vld=%b rdy=%b want 0 0 1",
                     sout_a, sout_vld_a, bus_a.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus_a.in_data  = 8'h5A;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sout_a !== next_word[7-i] || sout_vld_a !== 1'b1 || last_bit_a !== (i == 7)) begin
                failures++;
                $display("FAIL rmw_next%0d got sout=%b vld=%b last=%b want sout=%b vld=1 last=%b",
                         i, sout_a, sout_vld_a, last_bit_a, next_word[7-i], (i == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (sout_vld_a !== 1'b0) begin
            failures++; $display("FAIL rmw_idle got vld=%b want 0", sout_vld_a);
        end
        $display("test_reset_mid_word: 0xDB aborted, 0x5A sent");
    endtask

    // LSB-first instance with IDLE_BIT=1: 0x1B -> 1,1,0,1,1,0,0,0 and idle at 1.
    task automatic test_lsb_first();
        logic [7:0] exp_bits;
        exp_bits = 8'b1101_1000;
        @(negedge clk);
        checks++;
        if (sout_b !== 1'b1 || sout_vld_b !== 1'b0) begin
            failures++;
            $display("FAIL lsb_idle_pre got sout=%b vld=%b want 1 0", sout_b, sout_vld_b);
        end
        @(posedge clk); #1;
        bus_b.in_data  = 8'h1B;
        bus_b.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (sout_b !== exp_bits[7-i] || sout_vld_b !== 1'b1 || last_bit_b !== (i == 7)) begin
                failures++;
                $display("FAIL lsb_bit%0d got sout=%b vld=%b last=%b want sout=%b vld=1 last=%b",
                         i, sout_b, sout_vld_b, last_bit_b, exp_bits[7-i], (i == 7));
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (sout_b !== 1'b1 || sout_vld_b !== 1'b0) begin
                failures++;
                $display("FAIL lsb_idle_post%0d got sout=%b vld=%b want 1 0", i, sout_b, sout_vld_b);
            end
        end
        $display("test_lsb_first: word 0x1B sent LSB first");
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        bus_a.in_data  = '0;
        bus_a.in_valid = 1'b0;
        bus_b.in_data  = '0;
        bus_b.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
